// File: rtl/idwt_1d_inverse_stage.sv
// idwt_1d_inverse_stage: single-level inverse LeGall 5/3 lifting, one (s,d) pair in and one (even,odd) pair out per cycle.
module idwt_1d_inverse_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_first,
  input  logic          in_last,
  input  logic [DW-1:0] in_l,
  input  logic [DW-1:0] in_h,
  output logic          out_valid,
  output logic [DW-1:0] out_even,
  output logic [DW-1:0] out_odd,
  output logic          out_last,
  output logic          frame_err
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_n;
  logic [DW-1:0] d_prev, e_prev, dp_pend, d_left, even_new;
  logic [DW+1:0] pred_sum, upd_sum;
  logic acc, start, emit, flush, err;
  assign in_ready = state != FLUSH;
  assign acc = in_valid && in_ready;
  assign start = acc && in_first;
  assign emit = acc && !in_first && state == RUN;
  assign flush = state == FLUSH;
  assign err = acc && (in_first ? state == RUN : state == IDLE);
  // pair 0 mirrors its own detail coefficient as d[-1]
  assign d_left = start ? in_h : d_prev;
  assign pred_sum = {2'b00, d_left} + {2'b00, in_h} + (DW+2)'(2);
  assign even_new = in_l - DW'(pred_sum >> 2);
  assign upd_sum = {2'b00, e_prev} + {2'b00, even_new};
  always_comb begin
    state_n = state;
    if (flush) state_n = IDLE;
    else if (start || emit) state_n = in_last ? FLUSH : RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      d_prev    <= '0;
      e_prev    <= '0;
      dp_pend   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_err <= 1'b0;
      out_even  <= '0;
      out_odd   <= '0;
    end else begin
      state     <= state_n;
      frame_err <= err;
      out_valid <= emit || flush;
      out_last  <= flush;
      if (emit || flush) begin
        out_even <= e_prev;
        out_odd  <= flush ? dp_pend + e_prev : dp_pend + DW'(upd_sum >> 1);
      end
      if (start || emit) begin
        d_prev  <= in_h;
        e_prev  <= even_new;
        dp_pend <= in_h;
      end
    end
  end
endmodule

// File: doc/idwt_1d_inverse_stage.md
Name: idwt_1d_inverse_stage

Overview:
- Single-level 1-D inverse LeGall 5/3 integer lifting stage.
- Sits directly downstream of the forward 1-D DWT datapath. It consumes one low/high coefficient pair (s[n], d[n]) per cycle and reconstructs the even/odd sample pair (x[2n], x[2n+1]).
- Used to close the loop in simulation (forward -> inverse must reproduce the input frame) and as the synthesis-side block for reconstruction.

Parameters:
- DW, 8, sample and coefficient width; all arithmetic is modulo 2^DW.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, a coefficient pair is presented this cycle.
- in_ready, output, 1, the stage can accept a pair; low only in FLUSH.
- in_first, input, 1, marks pair n=0 of a frame.
- in_last, input, 1, marks the final pair of a frame; may coincide with in_first.
- in_l, input, DW, low-band coefficient s[n].
- in_h, input, DW, high-band coefficient d[n].
- out_valid, output, 1, out_even/out_odd hold a reconstructed pair this cycle.
- out_even, output, DW, x[2n].
- out_odd, output, DW, x[2n+1].
- out_last, output, 1, the pair on the output is the last of its frame.
- frame_err, output, 1, one-cycle pulse on a protocol violation.

Behaviour:
- Accept condition: in_valid && in_ready at a rising edge. There is no output backpressure; the consumer must take every out_valid cycle.
- Lifting equations:
  - even[n] = s[n] - ((d[n-1] + d[n] + 2) >> 2)
  - odd[n] = d[n] + ((even[n] + even[n+1]) >> 1)
- Width rules: sums are formed at DW+2 bits before shifting. Results are truncated to DW bits, giving wrap-around modulo 2^DW. Operands are treated as unsigned.
- Boundary extension (symmetric):
  - At n=0, d[-1] = d[0].
  - At the final pair N-1, even[N] = even[N-1], so odd[N-1] = d[N-1] + even[N-1] mod 2^DW.
- State registers: state, d_prev, e_prev (even of the pending pair), dp_pend (d of the pending pair).
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: in_ready=1.
    - Accepting a pair with in_first=1 computes even[0] and stores it. Next state is RUN, or FLUSH if in_last=1 as well. No output is produced.
    - Accepting a pair with in_first=0 discards it and pulses frame_err; the FSM stays in IDLE.
  - RUN: in_ready=1.
    - Accepting pair k (k>=1) registers out_even=e_prev, out_odd=dp_pend+((e_prev+even[k])>>1), out_valid=1, out_last=0. The new pair then becomes pending.
    - If in_last=1, next state is FLUSH.
    - If in_first=1 arrives in RUN, the pending pair is discarded with no output, frame_err pulses, and the new pair is treated as pair 0 of a new frame.
  - FLUSH: in_ready=0; input is ignored.
    - The edge registers out_even=e_prev, out_odd=dp_pend+e_prev, out_valid=1, out_last=1.
    - Next state is IDLE.
- Latency:
  - Output pair n becomes valid in the cycle after pair n+1 is accepted.
  - The last output pair is valid 2 cycles after the last input pair is accepted, provided input is back-to-back.
- Gaps (in_valid=0) in RUN: hold all state; out_valid=0.
- out_valid, out_last and frame_err are single-cycle and deassert on any edge without an emit or error.
- Reset values:
  - state=IDLE.
  - All data registers = 0.
  - out_valid = out_last = frame_err = 0.
  - in_ready = 1.
- Reset mid-frame: the partial frame is dropped and no output is produced for it.

Test Plan:
- Back-to-back frame (s,d) = (10,0), (33,10) with in_first on pair 0 and in_last on pair 1 -> out (10,20) with out_last=0, then (30,40) with out_last=1 on consecutive cycles; in_ready is low for exactly 1 cycle.
- Single-pair frame (s,d) = (0,4) with first=last=1 -> out (254,2) with out_last=1, showing wrap-around.
- Gaps: the same 2-pair frame with 3 idle cycles between pairs -> identical outputs; out_valid=0 during the gaps.
- Protocol error: in_first asserted again while in RUN -> frame_err pulses 1 cycle, the old pending pair is never emitted, and the new frame reconstructs correctly.
- Reset asserted during RUN, then a fresh frame -> no stale output, and the fresh frame output is correct. Stray in_valid with first=0 in IDLE -> frame_err pulse and no output.
- Loopback: forward-DWT level-1 output for random 16-sample frames -> output reproduces the input exactly, at 8-bit modulo arithmetic.
